// File: rtl/isa_types_pkg.sv
// Shared ISA-level types plus the memory arbiter's port/state encodings
// and the store-alignment rule.
package isa_types;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;

  typedef enum logic {
    ARB_IF   = 1'b0,
    ARB_DATA = 1'b1
  } arb_port_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ_WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            write;
    write_width_t    wwidth;
    logic [XLEN-1:0] wdata;
    arb_port_t       port;
  } arb_req_t;

  function automatic logic misaligned(input write_width_t w, input logic [1:0] a);
    case (w)
      write_halfword: return a[0];
      write_word:     return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && count_q != '1) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port memory between instruction
// fetch and load/store; each access walks IDLE -> ACCESS -> [READ_WAIT] -> RESP.
module mem_arbiter
  import isa_types::*;
#(
  parameter int STALL_CTR_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   if_req_valid,
  input  logic [XLEN-1:0]        if_req_addr,
  output logic                   if_req_ready,
  output logic                   if_resp_valid,
  output logic [XLEN-1:0]        if_resp_rdata,
  input  logic                   d_req_valid,
  input  logic                   d_req_write,
  input  logic [XLEN-1:0]        d_req_addr,
  input  write_width_t           d_req_wwidth,
  input  logic [XLEN-1:0]        d_req_wdata,
  output logic                   d_req_ready,
  output logic                   d_resp_valid,
  output logic [XLEN-1:0]        d_resp_rdata,
  output logic                   d_resp_err,
  output logic [XLEN-1:0]        mem_addr,
  output write_width_t           mem_wwidth,
  output logic                   mem_wenable,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic [STALL_CTR_W-1:0] if_stall_cnt,
  output logic [STALL_CTR_W-1:0] d_stall_cnt
);
  arb_state_t      state_q, state_d;
  arb_port_t       last_grant_q, last_grant_d;
  arb_req_t        req_q, req_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            grant_if, grant_d, store_bad, in_resp;

  // Readies are gated by reset so nothing looks accepted while held in reset.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE && reset_n) begin
      if (if_req_valid && d_req_valid) begin
        grant_if = (last_grant_q == ARB_DATA);
        grant_d  = !grant_if;
      end else begin
        grant_if = if_req_valid;
        grant_d  = d_req_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          req_d = '{addr: if_req_addr, write: 1'b0, wwidth: write_word,
                    wdata: '0, port: ARB_IF};
          last_grant_d = ARB_IF;
          state_d      = ACCESS;
        end else if (grant_d) begin
          req_d = '{addr: d_req_addr, write: d_req_write, wwidth: d_req_wwidth,
                    wdata: d_req_wdata, port: ARB_DATA};
          last_grant_d = ARB_DATA;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Stores skip READ_WAIT and report a zero load word.
        if (req_q.write) begin
          d_rdata_d = '0;
          state_d   = RESP;
        end else begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (req_q.port == ARB_IF) if_rdata_d = mem_rdata;
        else                      d_rdata_d  = mem_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_DATA;
      req_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign store_bad = misaligned(req_q.wwidth, req_q.addr[1:0]);
  assign in_resp   = (state_q == RESP);

  assign if_req_ready  = grant_if;
  assign d_req_ready   = grant_d;
  assign if_resp_valid = in_resp && (req_q.port == ARB_IF);
  assign d_resp_valid  = in_resp && (req_q.port == ARB_DATA);
  assign d_resp_err    = d_resp_valid && req_q.write && store_bad;
  assign if_resp_rdata = if_rdata_q;
  assign d_resp_rdata  = d_rdata_q;

  assign mem_addr    = req_q.addr;
  assign mem_wwidth  = req_q.wwidth;
  assign mem_wdata   = req_q.wdata;
  assign mem_wenable = (state_q == ACCESS) && req_q.write && !store_bad;

  sat_counter #(.W(STALL_CTR_W)) u_if_stall (
    .clock(clock), .reset_n(reset_n),
    .inc(if_req_valid && !if_req_ready), .count(if_stall_cnt)
  );

  sat_counter #(.W(STALL_CTR_W)) u_d_stall (
    .clock(clock), .reset_n(reset_n),
    .inc(d_req_valid && !d_req_ready), .count(d_stall_cnt)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, and a
// randomized run against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;
  import isa_types::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n;
  logic            if_req_valid, if_req_ready, if_resp_valid;
  logic [XLEN-1:0] if_req_addr, if_resp_rdata;
  logic            d_req_valid, d_req_write, d_req_ready, d_resp_valid, d_resp_err;
  logic [XLEN-1:0] d_req_addr, d_req_wdata, d_resp_rdata;
  write_width_t    d_req_wwidth, mem_wwidth;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic            mem_wenable;
  logic [15:0]     if_stall_cnt, d_stall_cnt;

  // Second instance with a narrow stall counter for the saturation check.
  logic            r4_n, if4_valid, d4_valid, d4_write;
  logic [XLEN-1:0] if4_addr, d4_addr, d4_wdata, mem4_rdata;
  write_width_t    d4_wwidth;
  logic            if4_ready, if4_resp_valid, d4_ready, d4_resp_valid, d4_resp_err, mem4_wenable;
  logic [XLEN-1:0] if4_resp_rdata, d4_resp_rdata, mem4_addr, mem4_wdata;
  write_width_t    mem4_wwidth;
  logic [3:0]      if4_stall_cnt, d4_stall_cnt;

  mem_arbiter #(.STALL_CTR_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wwidth(d_req_wwidth), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wenable(mem_wenable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
  );

  mem_arbiter #(.STALL_CTR_W(4)) dut4 (
    .clock(clock), .reset_n(r4_n),
    .if_req_valid(if4_valid), .if_req_addr(if4_addr), .if_req_ready(if4_ready),
    .if_resp_valid(if4_resp_valid), .if_resp_rdata(if4_resp_rdata),
    .d_req_valid(d4_valid), .d_req_write(d4_write), .d_req_addr(d4_addr),
    .d_req_wwidth(d4_wwidth), .d_req_wdata(d4_wdata), .d_req_ready(d4_ready),
    .d_resp_valid(d4_resp_valid), .d_resp_rdata(d4_resp_rdata), .d_resp_err(d4_resp_err),
    .mem_addr(mem4_addr), .mem_wwidth(mem4_wwidth), .mem_wenable(mem4_wenable),
    .mem_wdata(mem4_wdata), .mem_rdata(mem4_rdata),
    .if_stall_cnt(if4_stall_cnt), .d_stall_cnt(d4_stall_cnt)
  );

  // Behavioural memory: 256 bytes, little-endian, registered full-word read.
  logic [7:0] mem_b [256];
  logic [7:0] ref_b [256];

  always @(posedge clock) begin
    if (mem_wenable) begin
      case (mem_wwidth)
        write_byte: mem_b[mem_addr[7:0]] <= mem_wdata[7:0];
        write_halfword: begin
          mem_b[mem_addr[7:0]]        <= mem_wdata[7:0];
          mem_b[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
        end
        default: for (int i = 0; i < 4; i++) mem_b[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
      endcase
    end
    mem_rdata <= {mem_b[{mem_addr[7:2], 2'b11}], mem_b[{mem_addr[7:2], 2'b10}],
                  mem_b[{mem_addr[7:2], 2'b01}], mem_b[{mem_addr[7:2], 2'b00}]};
  end

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_b[b + 8'd3], ref_b[b + 8'd2], ref_b[b + 8'd1], ref_b[b]};
  endfunction

  a_if_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (if_req_valid && !if_req_ready) |=> if_req_valid);
  a_d_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (d_req_valid && !d_req_ready) |=> d_req_valid);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         is_data;
    logic         write;
    logic [31:0]  addr;
    write_width_t wwidth;
    logic [31:0]  wdata;
    logic [31:0]  exp_rdata;
    logic         exp_err;
  } vec_t;

  // One isolated transaction: ready at cycle 0, write enable at cycle 1 only
  // for good stores, response at cycle 3 (read) / 2 (write), one-cycle pulse.
  task automatic run_txn(input vec_t v);
    int lat, we_cnt, we_cyc;
    logic [31:0] rd;
    logic er, rv;
    lat = -1; we_cnt = 0; we_cyc = -1; rd = '0; er = 1'b0;
    @(posedge clock); #1;
    if (v.is_data) begin
      d_req_valid = 1'b1; d_req_write = v.write; d_req_addr = v.addr;
      d_req_wwidth = v.wwidth; d_req_wdata = v.wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = v.addr;
    end
    #1;
    chk("txn ready", v.is_data ? d_req_ready : if_req_ready, 1);
    for (int c = 0; c < 8; c++) begin
      if (mem_wenable) begin we_cnt++; we_cyc = c; end
      rv = v.is_data ? d_resp_valid : if_resp_valid;
      if (rv) begin
        lat = c; rd = v.is_data ? d_resp_rdata : if_resp_rdata; er = d_resp_err;
        break;
      end
      @(posedge clock); #1;
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
    end
    chk("txn latency", lat, (v.is_data && v.write) ? 2 : 3);
    chk("txn rdata", rd, v.exp_rdata);
    if (v.is_data) chk("txn err", er, v.exp_err);
    chk("txn wenable count", we_cnt, (v.is_data && v.write && !v.exp_err) ? 1 : 0);
    if (we_cnt == 1) chk("txn wenable cycle", we_cyc, 1);
    @(posedge clock); #2;
    chk("txn resp pulse", v.is_data ? d_resp_valid : if_resp_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl [13];
  int n_if, n_d, resp_at, next_idle, we_at;
  logic if_pend, d_pend, g_if, g_d, bad, resp_err;
  arb_port_t last, rp;
  logic [31:0] resp_data, e_if_st, e_d_st;

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    {mem_b[8'h13], mem_b[8'h12], mem_b[8'h11], mem_b[8'h10]} = 32'hDEADBEEF;
    {mem_b[8'h53], mem_b[8'h52], mem_b[8'h51], mem_b[8'h50]} = 32'h55667788;
    r4_n = 1'b0; if4_valid = 1'b0; d4_valid = 1'b0; d4_write = 1'b0;
    if4_addr = '0; d4_addr = '0; d4_wdata = '0; d4_wwidth = write_word; mem4_rdata = '0;

    // Reset state, with both requests raised to show readies stay low.
    reset_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = '0;
    d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = '0;
    d_req_wwidth = write_byte; d_req_wdata = '0;
    #2;
    chk("reset if_ready", if_req_ready, 0);
    chk("reset d_ready", d_req_ready, 0);
    chk("reset if_resp_valid", if_resp_valid, 0);
    chk("reset d_resp_valid", d_resp_valid, 0);
    chk("reset d_resp_err", d_resp_err, 0);
    chk("reset mem_wenable", mem_wenable, 0);
    chk("reset if_stall", if_stall_cnt, 0);
    chk("reset d_stall", d_stall_cnt, 0);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    #10 reset_n = 1'b1;

    tbl[0]  = '{1'b0, 1'b0, 32'h10, write_word,     32'h0,        32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h21, write_byte,     32'hA5,       32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h20, write_word,     32'h0,        32'h0000A500, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h22, write_word,     32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h20, write_word,     32'h0,        32'h0000A500, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'h33, write_halfword, 32'hBEEF,     32'h0,        1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'h32, write_halfword, 32'h1234,     32'h0,        1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h30, write_word,     32'h0,        32'h12340000, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h40, write_word,     32'hCAFEF00D, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h40, write_word,     32'h0,        32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h23, write_word,     32'h0,        32'h0000A500, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'h13, write_byte,     32'h5A,       32'h0,        1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h10, write_word,     32'h0,        32'h5AADBEEF, 1'b0};
    for (int i = 0; i < 13; i++) run_txn(tbl[i]);

    // Reset in the middle of a word store's ACCESS cycle.
    @(posedge clock); #1;
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h50;
    d_req_wwidth = write_word; d_req_wdata = 32'h11223344;
    #1 chk("midrst ready", d_req_ready, 1);
    @(posedge clock); #1;
    d_req_valid = 1'b0;
    #1 chk("midrst wenable in access", mem_wenable, 1);
    reset_n = 1'b0;
    #1 chk("midrst wenable drop", mem_wenable, 0);
    @(posedge clock); #3 reset_n = 1'b1;
    run_txn('{1'b1, 1'b0, 32'h50, write_word, 32'h0, 32'h55667788, 1'b0});

    // Both ports requesting continuously: IF reads, DATA word stores.
    reset_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h60;
    d_req_wwidth = write_word; d_req_wdata = 32'h0BADCAFE;
    @(posedge clock); #1 reset_n = 1'b1;
    #1;
    n_if = 0; n_d = 0;
    for (int t = 0; t < 20; t++) begin
      g_if = (t inside {0, 7, 14});
      g_d  = (t inside {4, 11, 18});
      chk("both if_ready", if_req_ready, g_if);
      chk("both d_ready", d_req_ready, g_d);
      chk("both if_stall", if_stall_cnt, t - n_if);
      chk("both d_stall", d_stall_cnt, t - n_d);
      n_if += int'(g_if); n_d += int'(g_d);
      @(posedge clock); #2;
    end
    reset_n = 1'b0;
    #1 if_req_valid = 1'b0; d_req_valid = 1'b0; d_req_write = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 256; i++) ref_b[i] = mem_b[i];
    if_pend = 1'b0; d_pend = 1'b0; last = ARB_DATA; rp = ARB_IF;
    next_idle = 0; resp_at = -1; we_at = -1; resp_data = '0; resp_err = 1'b0;
    e_if_st = '0; e_d_st = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clock); #1;
      if (!if_pend && $urandom_range(1, 0) == 1) begin
        if_pend = 1'b1;
        if_req_addr = {24'h0, 6'($urandom_range(63, 0)), 2'b00};
      end
      if (!d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1'b1;
        d_req_write = 1'($urandom_range(1, 0));
        d_req_addr = {24'h0, 8'($urandom_range(255, 0))};
        d_req_wwidth = write_width_t'($urandom_range(2, 0));
        d_req_wdata = $urandom;
      end
      if_req_valid = if_pend; d_req_valid = d_pend;
      #1;
      g_if = 1'b0; g_d = 1'b0;
      if (cyc >= next_idle) begin
        if (if_pend && d_pend) begin g_if = (last == ARB_DATA); g_d = !g_if; end
        else begin g_if = if_pend; g_d = d_pend; end
      end
      chk("rnd if_ready", if_req_ready, g_if);
      chk("rnd d_ready", d_req_ready, g_d);
      chk("rnd if_stall", if_stall_cnt, e_if_st);
      chk("rnd d_stall", d_stall_cnt, e_d_st);
      chk("rnd if_resp_valid", if_resp_valid, cyc == resp_at && rp == ARB_IF);
      chk("rnd d_resp_valid", d_resp_valid, cyc == resp_at && rp == ARB_DATA);
      if (cyc == resp_at && rp == ARB_IF) chk("rnd if_rdata", if_resp_rdata, resp_data);
      if (cyc == resp_at && rp == ARB_DATA) begin
        chk("rnd d_rdata", d_resp_rdata, resp_data);
        chk("rnd d_err", d_resp_err, resp_err);
      end
      chk("rnd mem_wenable", mem_wenable, cyc == we_at);
      if (if_pend && !g_if) e_if_st++;
      if (d_pend && !g_d) e_d_st++;
      if (g_if) begin
        rp = ARB_IF; last = ARB_IF; if_pend = 1'b0;
        resp_data = ref_word(if_req_addr[7:0]); resp_err = 1'b0;
        resp_at = cyc + 3; next_idle = cyc + 4; we_at = -1;
      end else if (g_d) begin
        rp = ARB_DATA; last = ARB_DATA; d_pend = 1'b0;
        if (d_req_write) begin
          bad = (d_req_wwidth == write_halfword && d_req_addr % 2 != 0) ||
                (d_req_wwidth == write_word && d_req_addr % 4 != 0);
          resp_data = '0; resp_err = bad;
          resp_at = cyc + 2; next_idle = cyc + 3; we_at = bad ? -1 : cyc + 1;
          if (!bad) begin
            if (d_req_wwidth == write_byte) n_d = 1;
            else if (d_req_wwidth == write_halfword) n_d = 2;
            else n_d = 4;
            for (int k = 0; k < n_d; k++) ref_b[8'(d_req_addr + k)] = d_req_wdata[8*k +: 8];
          end
        end else begin
          resp_data = ref_word(d_req_addr[7:0]); resp_err = 1'b0;
          resp_at = cyc + 3; next_idle = cyc + 4; we_at = -1;
        end
      end
    end

    // 4-bit stall counters: both ports requesting reads continuously.
    if4_valid = 1'b1; d4_valid = 1'b1;
    @(posedge clock); #1 r4_n = 1'b1;
    #1;
    for (int t = 0; t <= 40; t++) begin
      if (t == 16) begin
        chk("sat4 if_stall t16", if4_stall_cnt, 14);
        chk("sat4 d_stall t16", d4_stall_cnt, 14);
      end
      if (t == 17) chk("sat4 d_stall t17", d4_stall_cnt, 15);
      if (t == 18) chk("sat4 d_stall t18", d4_stall_cnt, 15);
      if (t == 40) begin
        chk("sat4 if_stall t40", if4_stall_cnt, 15);
        chk("sat4 d_stall t40", d4_stall_cnt, 15);
        chk("sat4 wenable", mem4_wenable, 0);
      end
      @(posedge clock); #2;
    end
    r4_n = 1'b0;
    #1 if4_valid = 1'b0; d4_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
